// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection; 1-cycle capture latency.
// Optional macro ID_EX_FLUSH_EN honours id_flush; otherwise only reset and hazards load bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rd,
    input  logic [DATA_W-1:0]     id_read_data1,
    input  logic [DATA_W-1:0]     id_read_data2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_flush,
    output logic [REG_ADDR_W-1:0] id_ex_rs,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [DATA_W-1:0]     id_ex_read_data1,
    output logic [DATA_W-1:0]     id_ex_read_data2,
    output logic [DATA_W-1:0]     id_ex_imm,
    output logic                  id_ex_reg_write,
    output logic                  id_ex_mem_read,
    output logic                  id_ex_mem_write,
    output logic                  id_ex_mem_to_reg,
    output logic                  id_ex_alu_src,
    output logic                  id_ex_reg_dst,
    output logic [1:0]            id_ex_alu_op,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  hazard_stall
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data1;
        logic [DATA_W-1:0]     data2;
        logic [DATA_W-1:0]     imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic                  reg_dst;
        logic [1:0]            alu_op;
    } id_ex_t;

    id_ex_t stage_q;
    id_ex_t stage_d;
    id_ex_t dec_in;
    logic   flush_act;

`ifdef ID_EX_FLUSH_EN
    assign flush_act = id_flush;
`else
    logic unused_flush;
    assign unused_flush = id_flush;
    assign flush_act    = 1'b0;
`endif

    // Hazard looks only at the registered load, so a bubble self-clears the stall.
    assign hazard_stall = stage_q.mem_read && (stage_q.rt != '0) &&
                          ((stage_q.rt == if_id_rs) || (stage_q.rt == if_id_rt));
    assign pc_write     = ~hazard_stall;
    assign if_id_write  = ~hazard_stall;

    always_comb begin
        dec_in            = '0;
        dec_in.rs         = if_id_rs;
        dec_in.rt         = if_id_rt;
        dec_in.rd         = if_id_rd;
        dec_in.data1      = id_read_data1;
        dec_in.data2      = id_read_data2;
        dec_in.imm        = id_imm;
        dec_in.reg_write  = id_reg_write;
        dec_in.mem_read   = id_mem_read;
        dec_in.mem_write  = id_mem_write;
        dec_in.mem_to_reg = id_mem_to_reg;
        dec_in.alu_src    = id_alu_src;
        dec_in.reg_dst    = id_reg_dst;
        dec_in.alu_op     = id_alu_op;
    end

    always_comb begin
        stage_d = dec_in;
        if (flush_act || hazard_stall) begin
            stage_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign id_ex_rs         = stage_q.rs;
    assign id_ex_rt         = stage_q.rt;
    assign id_ex_rd         = stage_q.rd;
    assign id_ex_read_data1 = stage_q.data1;
    assign id_ex_read_data2 = stage_q.data2;
    assign id_ex_imm        = stage_q.imm;
    assign id_ex_reg_write  = stage_q.reg_write;
    assign id_ex_mem_read   = stage_q.mem_read;
    assign id_ex_mem_write  = stage_q.mem_write;
    assign id_ex_mem_to_reg = stage_q.mem_to_reg;
    assign id_ex_alu_src    = stage_q.alu_src;
    assign id_ex_reg_dst    = stage_q.reg_dst;
    assign id_ex_alu_op     = stage_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: reference model of the ID/EX slot plus directed load-use scenarios.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        asrc;
        logic        rdst;
        logic [1:0]  aop;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  if_id_rs, if_id_rt, if_id_rd;
    logic [31:0] id_read_data1, id_read_data2, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [1:0]  id_alu_op;
    logic        id_flush;

    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic [31:0] id_ex_read_data1, id_ex_read_data2, id_ex_imm;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
    logic        id_ex_alu_src, id_ex_reg_dst;
    logic [1:0]  id_ex_alu_op;
    logic        pc_write, if_id_write, hazard_stall;

    int tests  = 0;
    int errors = 0;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .id_flush(id_flush),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_read_data1(id_ex_read_data1), .id_ex_read_data2(id_ex_read_data2),
        .id_ex_imm(id_ex_imm), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_reg_dst(id_ex_reg_dst), .id_ex_alu_op(id_ex_alu_op),
        .pc_write(pc_write), .if_id_write(if_id_write), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    slot_t dut_slot;
    assign dut_slot = '{id_ex_rs, id_ex_rt, id_ex_rd, id_ex_read_data1, id_ex_read_data2,
                        id_ex_imm, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
                        id_ex_mem_to_reg, id_ex_alu_src, id_ex_reg_dst, id_ex_alu_op};

    slot_t dec_slot;
    assign dec_slot = '{if_id_rs, if_id_rt, if_id_rd, id_read_data1, id_read_data2,
                        id_imm, id_reg_write, id_mem_read, id_mem_write,
                        id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op};

`ifdef ID_EX_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    // Model: what instruction currently occupies EX, and whether decode must wait on it.
    slot_t model;
    function automatic bit must_wait(slot_t ex, logic [4:0] rs, logic [4:0] rt);
        if (!ex.mr || ex.rt == 5'd0) return 1'b0;
        return (ex.rt == rs) || (ex.rt == rt);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model = '0;
        end else if ((FLUSH_EN && id_flush) || must_wait(model, if_id_rs, if_id_rt)) begin
            model = '0;
        end else begin
            model = dec_slot;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            bit w;
            w = must_wait(model, if_id_rs, if_id_rt);
            check("model_slot", 128'(dut_slot), 128'(model));
            check("model_stall", 128'(hazard_stall), 128'(w));
            check("model_pc_write", 128'(pc_write), 128'(!w));
            check("model_if_id_write", 128'(if_id_write), 128'(!w));
        end
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [5:0] ctl, input logic [1:0] aop, input logic fl);
        if_id_rs = rs; if_id_rt = rt; if_id_rd = rd;
        id_read_data1 = d1; id_read_data2 = d2; id_imm = imm;
        {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst} = ctl;
        id_alu_op = aop; id_flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ctl bit order: reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst
    localparam logic [5:0] CTL_LW  = 6'b110110;
    localparam logic [5:0] CTL_ADD = 6'b100001;
    localparam logic [5:0] CTL_SW  = 6'b001010;

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 6'b0, 2'd0, 1'b0);
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("reset_slot", 128'(dut_slot), 128'd0);
        check("reset_pc_write", 128'(pc_write), 128'd1);
        check("reset_stall", 128'(hazard_stall), 128'd0);

        // Plain add captured in one cycle.
        drive(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h0, CTL_ADD, 2'd2, 1'b0);
        #1 check("add_no_stall", 128'(hazard_stall), 128'd0);
        step();
        check("add_rs", 128'(id_ex_rs), 128'd3);
        check("add_rt", 128'(id_ex_rt), 128'd4);
        check("add_data1", 128'(id_ex_read_data1), 128'h11);
        check("add_data2", 128'(id_ex_read_data2), 128'h22);

        // lw $2 followed by dependent add: one bubble, then add enters EX.
        drive(5'd1, 5'd2, 5'd0, 32'h100, 32'h0, 32'h4, CTL_LW, 2'd0, 1'b0);
        step();
        drive(5'd2, 5'd5, 5'd6, 32'h33, 32'h44, 32'h0, CTL_ADD, 2'd2, 1'b0);
        #1;
        check("lu_stall", 128'(hazard_stall), 128'd1);
        check("lu_pc_write", 128'(pc_write), 128'd0);
        step();
        check("lu_bubble_rw", 128'(id_ex_reg_write), 128'd0);
        check("lu_bubble_rs", 128'(id_ex_rs), 128'd0);
        check("lu_stall_drops", 128'(hazard_stall), 128'd0);
        step();
        check("lu_add_rs", 128'(id_ex_rs), 128'd2);

        // Back-to-back dependent loads each stall exactly once (match on rt).
        drive(5'd1, 5'd7, 5'd0, 32'h0, 32'h0, 32'h8, CTL_LW, 2'd0, 1'b0);
        step();
        drive(5'd9, 5'd7, 5'd0, 32'h0, 32'h0, 32'hC, CTL_LW, 2'd0, 1'b0);
        #1 check("ld2_stall_rt", 128'(hazard_stall), 128'd1);
        step();
        step();
        check("ld2_captured_rt", 128'(id_ex_rt), 128'd7);
        check("ld2_chain_stall", 128'(hazard_stall), 128'd1);
        step();
        drive(5'd7, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0, CTL_ADD, 2'd2, 1'b0);
        step();

        // lw $0 never stalls.
        drive(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h10, CTL_LW, 2'd0, 1'b0);
        step();
        drive(5'd0, 5'd0, 5'd8, 32'h55, 32'h66, 32'h0, CTL_ADD, 2'd2, 1'b0);
        #1 check("r0_no_stall", 128'(hazard_stall), 128'd0);
        step();
        check("r0_captured_rw", 128'(id_ex_reg_write), 128'd1);

        // Flush of a valid add.
        drive(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h0, CTL_ADD, 2'd2, 1'b1);
        step();
        if (FLUSH_EN) check("flush_rw", 128'(id_ex_reg_write), 128'd0);
        else          check("noflush_rw", 128'(id_ex_reg_write), 128'd1);
        check("flush_rs", 128'(id_ex_rs), FLUSH_EN ? 128'd0 : 128'd3);

        // Flush during a hazard: bubble either way, stall outputs still follow the hazard.
        drive(5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h4, CTL_LW, 2'd0, 1'b0);
        step();
        drive(5'd2, 5'd3, 5'd4, 32'h7, 32'h8, 32'h0, CTL_ADD, 2'd2, 1'b1);
        #1 check("flush_haz_pc_write", 128'(pc_write), 128'd0);
        step();
        check("flush_haz_bubble", 128'(dut_slot), 128'd0);
        drive(5'd6, 5'd6, 5'd6, 32'hA, 32'hB, 32'h0, CTL_SW, 2'd0, 1'b0);
        step();

        // Reset pulsed mid-stall.
        drive(5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h4, CTL_LW, 2'd0, 1'b0);
        step();
        drive(5'd2, 5'd0, 5'd3, 32'h1, 32'h2, 32'h0, CTL_ADD, 2'd2, 1'b0);
        #1 check("rst_pre_stall", 128'(hazard_stall), 128'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_stall", 128'(hazard_stall), 128'd0);
        check("rst_mid_pc_write", 128'(pc_write), 128'd1);
        check("rst_mid_mem_read", 128'(id_ex_mem_read), 128'd0);
        #2 rst = 1'b0;
        step();
        check("post_rst_capture", 128'(id_ex_rs), 128'd2);
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
